// File: rtl/star_scan_sequencer_pkg.sv
// Shared constants, state encoding and box layout for the star scan sequencer.
package star_scan_sequencer_pkg;

   localparam int X_RES     = 60;
   localparam int Y_RES     = 60;
   localparam int XSZ       = 6;
   localparam int YSZ       = 6;
   localparam int ADDR_SZ   = 12;
   localparam int COL_SZ    = 3;
   localparam int THRESHOLD = 0;
   localparam int MAX_STARS = 8;
   localparam int IDX_SZ    = 3;

   localparam int BOX_SZ = 2*XSZ + 2*YSZ;

   // Packed box layout, MSB to LSB: {left, right, top, bottom}
   localparam int BOX_BOTTOM_LSB = 0;
   localparam int BOX_TOP_LSB    = YSZ;
   localparam int BOX_RIGHT_LSB  = 2*YSZ;
   localparam int BOX_LEFT_LSB   = 2*YSZ + XSZ;

   // Width-matched constants so compares stay the same size as the operands
   localparam logic [XSZ-1:0]    X_LAST    = XSZ'(X_RES - 1);
   localparam logic [YSZ-1:0]    Y_LAST    = YSZ'(Y_RES - 1);
   localparam logic [COL_SZ-1:0] THRESH    = COL_SZ'(THRESHOLD);
   localparam logic [IDX_SZ:0]   TBL_DEPTH = (IDX_SZ+1)'(MAX_STARS);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CHECK   = 3'd3,
      ST_LAUNCH  = 3'd4,
      ST_MEASURE = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   // 60-wide address translator: y*60 + x built from shifts (32+16+8+4)
   function automatic logic [ADDR_SZ-1:0] addr_of(input logic [XSZ-1:0] x,
                                                  input logic [YSZ-1:0] y);
      logic [ADDR_SZ-1:0] xe;
      logic [ADDR_SZ-1:0] ye;
      xe = {{(ADDR_SZ-XSZ){1'b0}}, x};
      ye = {{(ADDR_SZ-YSZ){1'b0}}, y};
      return (ye << 5) + (ye << 4) + (ye << 3) + (ye << 2) + xe;
   endfunction

endpackage

// File: rtl/star_box_table.sv
// Result table of star bounding boxes with a combinational read port and a
// parallel "is (x,y) inside any recorded box" compare.
module star_box_table
   import star_scan_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              clear,
   input  logic              we,
   input  logic [IDX_SZ-1:0] widx,
   input  logic [BOX_SZ-1:0] wbox,
   input  logic [IDX_SZ-1:0] ridx,
   output logic [BOX_SZ-1:0] rbox,
   input  logic [XSZ-1:0]    cx,
   input  logic [YSZ-1:0]    cy,
   output logic              covered
);

   logic [BOX_SZ-1:0]    boxes [MAX_STARS];
   logic [MAX_STARS-1:0] valid;

   // Valid bits: cleared by reset or at the start of each scan
   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid <= '0;
      end else if (clear) begin
         valid <= '0;
      end else if (we) begin
         valid[widx] <= 1'b1;
      end
   end

   // Box storage needs no reset; an entry is only trusted once its valid bit is set
   always_ff @(posedge clk) begin
      if (we) begin
         boxes[widx] <= wbox;
      end
   end

   assign rbox = boxes[ridx];

   // Inclusive unsigned containment test against every valid entry
   always_comb begin
      logic [XSZ-1:0] l;
      logic [XSZ-1:0] r;
      logic [YSZ-1:0] t;
      logic [YSZ-1:0] b;
      covered = 1'b0;
      for (int i = 0; i < MAX_STARS; i++) begin
         l = boxes[i][BOX_LEFT_LSB   +: XSZ];
         r = boxes[i][BOX_RIGHT_LSB  +: XSZ];
         t = boxes[i][BOX_TOP_LSB    +: YSZ];
         b = boxes[i][BOX_BOTTOM_LSB +: YSZ];
         if (valid[i] && (l <= cx) && (cx <= r) && (t <= cy) && (cy <= b)) begin
            covered = 1'b1;
         end
      end
   end

endmodule

// File: rtl/star_scan_sequencer.sv
// Raster-scans the image RAM, launches the extent measurer on each uncovered
// bright pixel and records the returned bounding boxes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start
// ADDR    | rd_addr presents current (x,y)
// WAIT    | RAM read latency
// CHECK   | classify pixel: launch, flag overflow, or advance
// LAUNCH  | one-cycle meas_start pulse with seed
// MEASURE | waiting for meas_done, then store box and advance
// DONE    | scan finished, scan_done high until next start
module star_scan_sequencer
   import star_scan_sequencer_pkg::*;
(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   output logic [ADDR_SZ-1:0]    rd_addr,
   input  logic [COL_SZ-1:0]     rd_data,
   output logic                  meas_start,
   output logic [XSZ-1:0]        meas_x,
   output logic [YSZ-1:0]        meas_y,
   input  logic                  meas_done,
   input  logic [XSZ-1:0]        meas_left,
   input  logic [XSZ-1:0]        meas_right,
   input  logic [YSZ-1:0]        meas_top,
   input  logic [YSZ-1:0]        meas_bottom,
   output logic [IDX_SZ:0]       star_count,
   output logic                  overflow,
   output logic                  busy,
   output logic                  scan_done,
   input  logic [IDX_SZ-1:0]     res_idx,
   output logic [2*XSZ+2*YSZ-1:0] res_box
);

   state_t         state;
   logic [XSZ-1:0] x;
   logic [YSZ-1:0] y;
   logic [XSZ-1:0] x_nxt;
   logic [YSZ-1:0] y_nxt;
   logic           last_px;
   logic           covered;
   logic           hit;
   logic           full;
   logic           tbl_clear;
   logic           tbl_we;

   assign rd_addr   = addr_of(x, y);
   assign last_px   = (x == X_LAST) && (y == Y_LAST);
   assign hit       = (rd_data > THRESH) && !covered;
   assign full      = (star_count >= TBL_DEPTH);
   assign tbl_clear = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign tbl_we    = (state == ST_MEASURE) && meas_done;

   // Next raster position
   always_comb begin
      x_nxt = x + XSZ'(1);
      y_nxt = y;
      if (x == X_LAST) begin
         x_nxt = '0;
         y_nxt = y + YSZ'(1);
      end
   end

   star_box_table u_table (
      .clk     (clk),
      .resetn  (resetn),
      .clear   (tbl_clear),
      .we      (tbl_we),
      .widx    (star_count[IDX_SZ-1:0]),
      .wbox    ({meas_left, meas_right, meas_top, meas_bottom}),
      .ridx    (res_idx),
      .rbox    (res_box),
      .cx      (x),
      .cy      (y),
      .covered (covered)
   );

   // Scan FSM with registered status and measurer handshake outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         x          <= '0;
         y          <= '0;
         star_count <= '0;
         overflow   <= 1'b0;
         meas_start <= 1'b0;
         meas_x     <= '0;
         meas_y     <= '0;
         busy       <= 1'b0;
         scan_done  <= 1'b0;
      end else begin
         meas_start <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  star_count <= '0;
                  overflow   <= 1'b0;
                  x          <= '0;
                  y          <= '0;
                  busy       <= 1'b1;
                  scan_done  <= 1'b0;
                  state      <= ST_ADDR;
               end
            end
            ST_ADDR: state <= ST_WAIT;
            ST_WAIT: state <= ST_CHECK;
            ST_CHECK: begin
               if (hit && !full) begin
                  meas_start <= 1'b1;
                  meas_x     <= x;
                  meas_y     <= y;
                  state      <= ST_LAUNCH;
               end else begin
                  if (hit) begin
                     overflow <= 1'b1;
                  end
                  x <= x_nxt;
                  y <= y_nxt;
                  if (last_px) begin
                     busy      <= 1'b0;
                     scan_done <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     state <= ST_ADDR;
                  end
               end
            end
            ST_LAUNCH: state <= ST_MEASURE;
            ST_MEASURE: begin
               if (meas_done) begin
                  star_count <= star_count + (IDX_SZ+1)'(1);
                  x          <= x_nxt;
                  y          <= y_nxt;
                  if (last_px) begin
                     busy      <= 1'b0;
                     scan_done <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     state <= ST_ADDR;
                  end
               end
            end
            default: begin
               busy      <= 1'b0;
               scan_done <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_star_scan_sequencer.sv
// Directed bench for star_scan_sequencer: behavioural image RAM plus an
// inline measurer that answers each launch with a box grown from the seed.
module tb_star_scan_sequencer;

   localparam int NPIX   = 3600;
   localparam int BUDGET = 12000;

   logic        clk;
   logic        resetn;
   logic        start;
   logic [11:0] rd_addr;
   logic [2:0]  rd_data;
   logic        meas_start;
   logic [5:0]  meas_x;
   logic [5:0]  meas_y;
   logic        meas_done;
   logic [5:0]  meas_left;
   logic [5:0]  meas_right;
   logic [5:0]  meas_top;
   logic [5:0]  meas_bottom;
   logic [3:0]  star_count;
   logic        overflow;
   logic        busy;
   logic        scan_done;
   logic [2:0]  res_idx;
   logic [23:0] res_box;

   logic [2:0] mem [NPIX];

   int checks   = 0;
   int failures = 0;
   int launches;
   int cycles;
   int seed_x [16];
   int seed_y [16];

   star_scan_sequencer dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .meas_start  (meas_start),
      .meas_x      (meas_x),
      .meas_y      (meas_y),
      .meas_done   (meas_done),
      .meas_left   (meas_left),
      .meas_right  (meas_right),
      .meas_top    (meas_top),
      .meas_bottom (meas_bottom),
      .star_count  (star_count),
      .overflow    (overflow),
      .busy        (busy),
      .scan_done   (scan_done),
      .res_idx     (res_idx),
      .res_box     (res_box)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read image RAM, q valid one cycle after the address
   always @(posedge clk) begin
      rd_data <= (rd_addr < 12'(NPIX)) ? mem[rd_addr] : 3'd0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_frame();
      for (int i = 0; i < NPIX; i++) mem[i] = 3'd0;
   endtask

   task automatic set_px(input int px, input int py, input logic [2:0] v);
      mem[py*60 + px] = v;
   endtask

   // Called #1 after a posedge. Pulses start, serves launches with a box of
   // extent (mw,mh) from the seed, and optionally at cycle disturb_at pulses a
   // stray start plus a stray full-frame meas_done.
   task automatic run_scan(input int mw, input int mh, input int disturb_at);
      launches = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      cycles = 1;
      while (!scan_done && cycles < BUDGET) begin
         if (meas_start) begin
            if (launches < 16) begin
               seed_x[launches] = int'(meas_x);
               seed_y[launches] = int'(meas_y);
            end
            launches++;
            repeat (3) begin
               @(posedge clk); #1;
               cycles++;
               chk("meas_start_one_cycle", meas_start, 0);
               chk("busy_in_measure", busy, 1);
            end
            meas_left   = meas_x;
            meas_right  = 6'(int'(meas_x) + mw);
            meas_top    = meas_y;
            meas_bottom = 6'(int'(meas_y) + mh);
            meas_done   = 1'b1;
            @(posedge clk); #1;
            cycles++;
            meas_done = 1'b0;
         end else begin
            if (cycles == disturb_at) begin
               start       = 1'b1;
               meas_done   = 1'b1;
               meas_left   = 6'd0;
               meas_right  = 6'd59;
               meas_top    = 6'd0;
               meas_bottom = 6'd59;
            end
            @(posedge clk); #1;
            cycles++;
            start     = 1'b0;
            meas_done = 1'b0;
         end
      end
      chk("scan_completed", scan_done, 1);
   endtask

   initial begin
      resetn      = 1'b0;
      start       = 1'b0;
      meas_done   = 1'b0;
      meas_left   = '0;
      meas_right  = '0;
      meas_top    = '0;
      meas_bottom = '0;
      res_idx     = '0;
      clear_frame();
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      // Reset state
      chk("rst_busy", busy, 0);
      chk("rst_scan_done", scan_done, 0);
      chk("rst_star_count", star_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_meas_start", meas_start, 0);
      chk("rst_rd_addr", rd_addr, 0);

      // All-zero frame: full scan time and no launches
      run_scan(0, 0, -1);
      chk("zero_cycles", cycles, 10801);
      chk("zero_launches", launches, 0);
      chk("zero_star_count", star_count, 0);
      chk("zero_busy", busy, 0);

      // Single pixel at (10,5); restart from DONE without reset
      clear_frame();
      set_px(10, 5, 3'd4);
      run_scan(0, 0, -1);
      chk("single_launches", launches, 1);
      chk("single_seed_x", seed_x[0], 10);
      chk("single_seed_y", seed_y[0], 5);
      chk("single_star_count", star_count, 1);
      chk("single_cycles", cycles, 10805);
      res_idx = 3'd0; #1;
      chk("single_box0", res_box, {6'd10, 6'd10, 6'd5, 6'd5});

      // Same frame again with a stray start and stray meas_done mid-scan;
      // the previous table must have been cleared by the restart
      run_scan(0, 0, 100);
      chk("disturb_launches", launches, 1);
      chk("disturb_seed_x", seed_x[0], 10);
      chk("disturb_seed_y", seed_y[0], 5);
      chk("disturb_star_count", star_count, 1);
      chk("disturb_cycles", cycles, 10805);
      chk("disturb_overflow", overflow, 0);
      res_idx = 3'd0; #1;
      chk("disturb_box0", res_box, {6'd10, 6'd10, 6'd5, 6'd5});

      // 3x3 star: one launch, remaining pixels covered
      clear_frame();
      for (int yy = 30; yy <= 32; yy++)
         for (int xx = 20; xx <= 22; xx++)
            set_px(xx, yy, 3'd7);
      run_scan(2, 2, -1);
      chk("blob_launches", launches, 1);
      chk("blob_seed_x", seed_x[0], 20);
      chk("blob_seed_y", seed_y[0], 30);
      chk("blob_star_count", star_count, 1);
      res_idx = 3'd0; #1;
      chk("blob_box0", res_box, {6'd20, 6'd22, 6'd30, 6'd32});

      // Nine separated pixels: table fills at eight, ninth sets overflow
      clear_frame();
      for (int i = 0; i < 9; i++) set_px(5*i + 1, 6*i + 2, 3'd1);
      run_scan(0, 0, -1);
      chk("nine_launches", launches, 8);
      chk("nine_star_count", star_count, 8);
      chk("nine_overflow", overflow, 1);
      chk("nine_seed7_x", seed_x[7], 36);
      chk("nine_seed7_y", seed_y[7], 44);
      res_idx = 3'd7; #1;
      chk("nine_box7", res_box, {6'd36, 6'd36, 6'd44, 6'd44});
      res_idx = 3'd3; #1;
      chk("nine_box3", res_box, {6'd16, 6'd16, 6'd20, 6'd20});

      // Last pixel (59,59): launched last, DONE after measurement
      clear_frame();
      set_px(59, 59, 3'd2);
      run_scan(0, 0, -1);
      chk("last_launches", launches, 1);
      chk("last_seed_x", seed_x[0], 59);
      chk("last_seed_y", seed_y[0], 59);
      chk("last_star_count", star_count, 1);
      chk("last_cycles", cycles, 10805);
      chk("last_overflow", overflow, 0);

      // Reset during MEASURE aborts; a later meas_done is ignored
      clear_frame();
      set_px(10, 5, 3'd4);
      start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      cycles = 0;
      while (!meas_start && cycles < 2000) begin
         @(posedge clk); #1;
         cycles++;
      end
      chk("abort_launch_seen", meas_start, 1);
      @(posedge clk); #1;
      chk("abort_busy_before", busy, 1);
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_scan_done", scan_done, 0);
      chk("abort_star_count", star_count, 0);
      chk("abort_meas_start", meas_start, 0);
      meas_left   = 6'd1;
      meas_right  = 6'd2;
      meas_top    = 6'd3;
      meas_bottom = 6'd4;
      meas_done   = 1'b1;
      @(posedge clk); #1;
      meas_done = 1'b0;
      @(posedge clk); #1;
      chk("late_done_star_count", star_count, 0);
      chk("late_done_busy", busy, 0);
      chk("late_done_scan_done", scan_done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
